// File: rtl/lc3b_types.sv
// Shared LC-3b types: word type, memory-op opcodes and MEM-stage FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_LDB = 4'b0010,
        OP_STB = 4'b0011,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_LDI = 4'b1010,
        OP_STI = 4'b1011
    } lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS1 = 2'd1,
        ACCESS2 = 2'd2,
        DONE    = 2'd3
    } mem_stage_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between the pipeline and the 16-bit data memory.
// Combinational: load byte select/sign-extend, store mask and lane replication.
import lc3b_types::*;

module mem_align (
    input  logic       byte_op,
    input  logic       wr,
    input  logic       addr_lsb,
    input  lc3b_word   store_data,
    input  lc3b_word   rdata,
    output logic [1:0] wmask,
    output lc3b_word   wdata,
    output lc3b_word   load_data
);

    logic [7:0] sel_byte;

    always_comb begin
        wmask = 2'b00;
        if (wr) begin
            wmask = byte_op ? (addr_lsb ? 2'b10 : 2'b01) : 2'b11;
        end
        wdata     = byte_op ? {2{store_data[7:0]}} : store_data;
        sel_byte  = addr_lsb ? rdata[15:8] : rdata[7:0];
        load_data = byte_op ? {{8{sel_byte[7]}}, sel_byte} : rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: sequences single and indirect data-memory accesses.
// Stalls upstream from memory-op detection until the final response; DONE releases it.
import lc3b_types::*;

module mem_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_valid,
    input  lc3b_word   mem_ir,
    input  lc3b_word   mem_address,
    input  lc3b_word   mem_store_data,
    input  lc3b_word   dmem_rdata,
    input  logic       dmem_resp,
    output lc3b_word   dmem_address,
    output logic       dmem_read,
    output logic       dmem_write,
    output logic [1:0] dmem_wmask,
    output lc3b_word   dmem_wdata,
    output lc3b_word   wb_mem_data,
    output logic       mem_stall
);

    mem_stage_state_t state_q, state_d;
    lc3b_word         ptr_q, ptr_d;
    lc3b_word         wb_q, wb_d;

    logic       is_mem, is_byte, is_store, is_ind;
    logic       req_rd, req_wr, req_byte;
    lc3b_word   req_addr, load_data;
    logic       unused_ir;

    assign unused_ir = ^mem_ir[11:0];

    always_comb begin
        is_mem   = 1'b1;
        is_byte  = 1'b0;
        is_store = 1'b0;
        is_ind   = 1'b0;
        case (mem_ir[15:12])
            OP_LDB:  is_byte = 1'b1;
            OP_STB:  begin is_byte = 1'b1; is_store = 1'b1; end
            OP_LDR:  ;
            OP_STR:  is_store = 1'b1;
            OP_LDI:  is_ind = 1'b1;
            OP_STI:  begin is_ind = 1'b1; is_store = 1'b1; end
            default: is_mem = 1'b0;
        endcase
    end

    // Request outputs depend only on registered state and the held EX/MEM slot.
    always_comb begin
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = mem_address;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: mem_stall = mem_valid && is_mem;
            ACCESS1: begin
                mem_stall = 1'b1;
                req_byte  = is_byte;
                req_wr    = is_store && !is_ind;
                req_rd    = !(is_store && !is_ind);
            end
            ACCESS2: begin
                mem_stall = 1'b1;
                req_addr  = ptr_q;
                req_wr    = is_store;
                req_rd    = !is_store;
            end
            default: ;
        endcase
    end

    mem_align u_align (
        .byte_op    (req_byte),
        .wr         (req_wr),
        .addr_lsb   (req_addr[0]),
        .store_data (mem_store_data),
        .rdata      (dmem_rdata),
        .wmask      (dmem_wmask),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    assign dmem_address = {req_addr[15:1], 1'b0};
    assign dmem_read    = req_rd;
    assign dmem_write   = req_wr;
    assign wb_mem_data  = wb_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wb_d    = wb_q;
        case (state_q)
            IDLE: if (mem_valid && is_mem) state_d = ACCESS1;
            ACCESS1: if (dmem_resp) begin
                if (is_ind) begin
                    ptr_d   = dmem_rdata;
                    state_d = ACCESS2;
                end else begin
                    if (!is_store) wb_d = load_data;
                    state_d = DONE;
                end
            end
            ACCESS2: if (dmem_resp) begin
                if (!is_store) wb_d = load_data;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wb_q    <= wb_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: hand table of memory ops, reset-in-ACCESS2 sequence,
// then random ops checked against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk, rst_n, mem_valid, dmem_resp;
    logic [15:0] mem_ir, mem_address, mem_store_data, dmem_rdata;
    logic [15:0] dmem_address, dmem_wdata, wb_mem_data;
    logic        dmem_read, dmem_write, mem_stall;
    logic [1:0]  dmem_wmask;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ir(mem_ir),
        .mem_address(mem_address), .mem_store_data(mem_store_data),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .wb_mem_data(wb_mem_data), .mem_stall(mem_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kind codes: 1 = read, 2 = write
    typedef struct {
        logic        valid;
        logic [15:0] ir, addr, sdata, rd1, rd2;
        int          w1, w2;
        int          n;
        int          k1; logic [15:0] a1; logic [1:0] m1; logic [15:0] d1;
        int          k2; logic [15:0] a2; logic [1:0] m2; logic [15:0] d2;
        int          stall;
        logic [15:0] wb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          obs_n, obs_stall;
    bit          obs_unstable, obs_timeout;
    int          obs_k[2];
    logic [15:0] obs_a[2], obs_d[2];
    logic [1:0]  obs_m[2];
    logic [15:0] obs_wb;
    logic [15:0] model_wb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkvec(
        input logic valid, input logic [15:0] ir, addr, sdata, rd1, rd2,
        input int w1, w2, n,
        input int k1, input logic [15:0] a1, input logic [1:0] m1, input logic [15:0] d1,
        input int k2, input logic [15:0] a2, input logic [1:0] m2, input logic [15:0] d2,
        input int stall, input logic [15:0] wb);
        vec_t v;
        v.valid = valid; v.ir = ir; v.addr = addr; v.sdata = sdata; v.rd1 = rd1; v.rd2 = rd2;
        v.w1 = w1; v.w2 = w2; v.n = n;
        v.k1 = k1; v.a1 = a1; v.m1 = m1; v.d1 = d1;
        v.k2 = k2; v.a2 = a2; v.m2 = m2; v.d2 = d2;
        v.stall = stall; v.wb = wb;
        return v;
    endfunction

    // Transaction-level view: which accesses the op makes and what it returns.
    function automatic vec_t model(input vec_t v, input logic [15:0] prev_wb);
        vec_t r;
        int op, b;
        bit mem, byt, st, ind;
        r = v;
        op  = int'(v.ir[15:12]);
        mem = v.valid && (op == 2 || op == 3 || op == 6 || op == 7 || op == 10 || op == 11);
        byt = (op == 2 || op == 3);
        st  = (op == 3 || op == 7 || op == 11);
        ind = (op == 10 || op == 11);
        r.n = 0; r.stall = 0; r.wb = prev_wb;
        r.k1 = 0; r.a1 = 0; r.m1 = 0; r.d1 = 0; r.k2 = 0; r.a2 = 0; r.m2 = 0; r.d2 = 0;
        if (mem) begin
            r.n     = ind ? 2 : 1;
            r.stall = 1 + (v.w1 + 1) + (ind ? v.w2 + 1 : 0);
            r.a1    = 16'(int'(v.addr) - int'(v.addr) % 2);
            r.k1    = (st && !ind) ? 2 : 1;
            r.m1    = (r.k1 == 2) ? (byt ? ((v.addr % 2) ? 2'd2 : 2'd1) : 2'd3) : 2'd0;
            r.d1    = byt ? 16'((int'(v.sdata) % 256) * 257) : v.sdata;
            if (ind) begin
                r.a2 = 16'(int'(v.rd1) - int'(v.rd1) % 2);
                r.k2 = st ? 2 : 1;
                r.m2 = st ? 2'd3 : 2'd0;
                r.d2 = v.sdata;
            end
            if (!st) begin
                if (byt) begin
                    b    = (v.addr % 2) ? int'(v.rd1) / 256 : int'(v.rd1) % 256;
                    r.wb = 16'((b >= 128) ? b + 65280 : b);
                end else begin
                    r.wb = ind ? v.rd2 : v.rd1;
                end
            end
        end
        return r;
    endfunction

    // Issue one EX/MEM slot and act as the memory, recording what the DUT requested.
    task automatic run_op(input vec_t v);
        int cyc, wcnt, want, k, fk;
        logic [15:0] fa, fd;
        logic [1:0]  fm;
        bit done;
        mem_valid = v.valid; mem_ir = v.ir; mem_address = v.addr;
        mem_store_data = v.sdata; dmem_resp = 1'b0;
        obs_n = 0; obs_stall = 0; obs_unstable = 0; obs_timeout = 0; obs_wb = 16'h0;
        for (int i = 0; i < 2; i++) begin
            obs_k[i] = 0; obs_a[i] = 0; obs_m[i] = 0; obs_d[i] = 0;
        end
        cyc = 0; wcnt = 0; done = 0; fk = 0; fa = 0; fm = 0; fd = 0;
        while (!done) begin
            @(negedge clk);
            k = int'({dmem_write, dmem_read});
            if (mem_stall) obs_stall++;
            if (k != 0) begin
                if (wcnt == 0) begin
                    fk = k; fa = dmem_address; fm = dmem_wmask; fd = dmem_wdata;
                end else if (k != fk || dmem_address != fa || dmem_wmask != fm ||
                             (dmem_write && dmem_wdata != fd)) begin
                    obs_unstable = 1;
                end
                want = (obs_n == 0) ? v.w1 : v.w2;
                if (wcnt == want) begin
                    if (obs_n < 2) begin
                        obs_k[obs_n] = fk; obs_a[obs_n] = fa;
                        obs_m[obs_n] = fm; obs_d[obs_n] = fd;
                    end
                    dmem_rdata = (obs_n == 0) ? v.rd1 : v.rd2;
                    dmem_resp  = 1'b1;
                    obs_n++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else if (!mem_stall && (obs_stall > 0 || cyc >= 3)) begin
                done   = 1;
                obs_wb = wb_mem_data;
            end
            cyc++;
            if (!done && cyc >= 60) begin
                obs_timeout = 1;
                done = 1;
            end
            @(posedge clk);
            #1;
            dmem_resp  = 1'b0;
            dmem_rdata = 16'hDEAD;
        end
        mem_valid = 1'b0;
    endtask

    task automatic compare_vec(input vec_t v, input string tag);
        chk($sformatf("%s timeout", tag), 32'(obs_timeout), 32'd0);
        chk($sformatf("%s n_access", tag), obs_n, v.n);
        chk($sformatf("%s stall_cycles", tag), obs_stall, v.stall);
        chk($sformatf("%s wb_mem_data", tag), obs_wb, v.wb);
        chk($sformatf("%s req_stable", tag), 32'(obs_unstable), 32'd0);
        if (v.n >= 1 && obs_n >= 1) begin
            chk($sformatf("%s kind1", tag), obs_k[0], v.k1);
            chk($sformatf("%s addr1", tag), obs_a[0], v.a1);
            chk($sformatf("%s wmask1", tag), obs_m[0], v.m1);
            if (v.k1 == 2) chk($sformatf("%s wdata1", tag), obs_d[0], v.d1);
        end
        if (v.n >= 2 && obs_n >= 2) begin
            chk($sformatf("%s kind2", tag), obs_k[1], v.k2);
            chk($sformatf("%s addr2", tag), obs_a[1], v.a2);
            chk($sformatf("%s wmask2", tag), obs_m[1], v.m2);
            if (v.k2 == 2) chk($sformatf("%s wdata2", tag), obs_d[1], v.d2);
        end
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        int pool[6];
        int op;

        pool[0] = 2; pool[1] = 3; pool[2] = 6; pool[3] = 7; pool[4] = 10; pool[5] = 11;
        //            vld ir        addr      sdata     rd1       rd2       w1 w2 n  k1 a1        m1 d1        k2 a2        m2 d2        st wb
        tbl[0]  = mkvec(1, 16'h6283, 16'h3006, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 1, 1, 16'h3006, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 2, 16'hBEEF);
        tbl[1]  = mkvec(1, 16'h2040, 16'h3007, 16'h0000, 16'h80AA, 16'h0000, 0, 0, 1, 1, 16'h3006, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 2, 16'hFF80);
        tbl[2]  = mkvec(1, 16'h2040, 16'h3006, 16'h0000, 16'h80AA, 16'h0000, 0, 0, 1, 1, 16'h3006, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 2, 16'hFFAA);
        tbl[3]  = mkvec(1, 16'h3040, 16'h4001, 16'h1234, 16'h5555, 16'h0000, 0, 0, 1, 2, 16'h4000, 2, 16'h3434, 0, 16'h0000, 0, 16'h0000, 2, 16'hFFAA);
        tbl[4]  = mkvec(1, 16'hB200, 16'h5000, 16'hABCD, 16'h6002, 16'h1111, 2, 2, 2, 1, 16'h5000, 0, 16'h0000, 2, 16'h6002, 3, 16'hABCD, 7, 16'hFFAA);
        tbl[5]  = mkvec(1, 16'hA200, 16'h1235, 16'h0000, 16'h2001, 16'h5A5A, 0, 0, 2, 1, 16'h1234, 0, 16'h0000, 1, 16'h2000, 0, 16'h0000, 3, 16'h5A5A);
        tbl[6]  = mkvec(1, 16'h7000, 16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 1, 0, 1, 2, 16'h7FFE, 3, 16'h8001, 0, 16'h0000, 0, 16'h0000, 3, 16'h5A5A);
        tbl[7]  = mkvec(1, 16'h1261, 16'h3006, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h5A5A);
        tbl[8]  = mkvec(0, 16'h6283, 16'h3006, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h5A5A);
        tbl[9]  = mkvec(1, 16'h3040, 16'h4000, 16'h12F0, 16'h0000, 16'h0000, 0, 0, 1, 2, 16'h4000, 1, 16'hF0F0, 0, 16'h0000, 0, 16'h0000, 2, 16'h5A5A);
        tbl[10] = mkvec(1, 16'h2040, 16'h0001, 16'h0000, 16'h7F00, 16'h0000, 3, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 5, 16'h007F);

        rst_n = 1'b0; mem_valid = 1'b0; mem_ir = 16'h0; mem_address = 16'h0;
        mem_store_data = 16'h0; dmem_rdata = 16'h0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dmem_read", dmem_read, 1'b0);
        chk("reset dmem_write", dmem_write, 1'b0);
        chk("reset dmem_wmask", dmem_wmask, 2'b00);
        chk("reset mem_stall", mem_stall, 1'b0);
        chk("reset wb_mem_data", wb_mem_data, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            run_op(tbl[i]);
            compare_vec(tbl[i], $sformatf("tbl%0d", i));
        end
        model_wb = tbl[10].wb;

        // Reset while the LDI is waiting on its second access.
        mem_valid = 1'b1; mem_ir = 16'hA000; mem_address = 16'h7000;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ldi acc1 read", dmem_read, 1'b1);
        dmem_resp = 1'b1; dmem_rdata = 16'h7100;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("rst_ldi acc2 read", dmem_read, 1'b1);
        chk("rst_ldi acc2 addr", dmem_address, 16'h7100);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ldi read drops", dmem_read, 1'b0);
        chk("rst_ldi write low", dmem_write, 1'b0);
        chk("rst_ldi wb cleared", wb_mem_data, 16'h0000);
        mem_valid = 1'b0;
        #1;
        chk("rst_ldi stall low", mem_stall, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 16'h1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("late_resp%0d read", c), dmem_read, 1'b0);
            chk($sformatf("late_resp%0d stall", c), mem_stall, 1'b0);
            chk($sformatf("late_resp%0d wb", c), wb_mem_data, 16'h0000);
        end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        model_wb = 16'h0000;

        for (int r = 0; r < 40; r++) begin
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : pool[$urandom_range(0, 5)];
            v.valid = ($urandom_range(0, 7) != 0);
            v.ir    = {4'(op), 12'($urandom)};
            v.addr  = 16'($urandom);
            v.sdata = 16'($urandom);
            v.rd1   = 16'($urandom);
            v.rd2   = 16'($urandom);
            v.w1    = int'($urandom_range(0, 2));
            v.w2    = int'($urandom_range(0, 2));
            v = model(v, model_wb);
            run_op(v);
            compare_vec(v, $sformatf("rnd%0d op%0h", r, op));
            model_wb = v.wb;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
